// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer with BCD load, run/pause control, expiry pulse and 7-seg drive.
// Optional COUNTDOWN_FLASH_EN: flash 00:00 at 1 Hz while expired.
module countdown_timer_mmss #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] ld_m1,
  input  logic [3:0] ld_m0,
  input  logic [2:0] ld_s1,
  input  logic [3:0] ld_s0,
  input  logic       start,
  input  logic       stop,
  output logic [6:0] m1,
  output logic [6:0] m0,
  output logic [6:0] s1,
  output logic [6:0] s0,
  output logic [3:0] dots,
  output logic       running,
  output logic       expired,
  output logic       done
);
  // state   | meaning
  // IDLE    | loaded or reset, waiting for start
  // RUN     | counting down once per second
  // PAUSE   | frozen, sub-second count held
  // EXPIRED | reached 00:00, waiting for load
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
  localparam logic [CW-1:0] HALF = CW'(TICKS_PER_SEC / 2);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_m1, r_s1;
  logic [3:0]    r_m0, r_s0;
  logic          r_done;

  logic [2:0] w_n_m1, w_n_s1;
  logic [3:0] w_n_m0, w_n_s0;
  logic       w_dec_zero;
  logic       w_nonzero;
  logic       w_blank;
  logic       w_colon_n;

  always_comb begin
    w_n_m1 = r_m1;
    w_n_m0 = r_m0;
    w_n_s1 = r_s1;
    w_n_s0 = r_s0;
    if (r_s0 != 4'd0) begin
      w_n_s0 = r_s0 - 4'd1;
    end else begin
      w_n_s0 = 4'd9;
      if (r_s1 != 3'd0) begin
        w_n_s1 = r_s1 - 3'd1;
      end else begin
        w_n_s1 = 3'd5;
        if (r_m0 != 4'd0) begin
          w_n_m0 = r_m0 - 4'd1;
        end else begin
          w_n_m0 = 4'd9;
          w_n_m1 = r_m1 - 3'd1;
        end
      end
    end
  end

  assign w_dec_zero = (r_m1 == 3'd0) && (r_m0 == 4'd0) && (r_s1 == 3'd0) && (r_s0 == 4'd1);
  assign w_nonzero  = (r_m1 != 3'd0) || (r_m0 != 4'd0) || (r_s1 != 3'd0) || (r_s0 != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_m1    <= 3'd0;
      r_m0    <= 4'd0;
      r_s1    <= 3'd0;
      r_s0    <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_m1    <= (ld_m1 > 3'd5) ? 3'd5 : ld_m1;
        r_m0    <= (ld_m0 > 4'd9) ? 4'd9 : ld_m0;
        r_s1    <= (ld_s1 > 3'd5) ? 3'd5 : ld_s1;
        r_s0    <= (ld_s0 > 4'd9) ? 4'd9 : ld_s0;
        r_cnt   <= '0;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (!stop && start && w_nonzero) r_state <= RUN;
          end
          RUN: begin
            if (stop) begin
              r_state <= PAUSE;
            end else if (r_cnt == LAST) begin
              r_cnt <= '0;
              r_m1  <= w_n_m1;
              r_m0  <= w_n_m0;
              r_s1  <= w_n_s1;
              r_s0  <= w_n_s0;
              if (w_dec_zero) begin
                r_state <= EXPIRED;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PAUSE: begin
            // Resume keeps the held count so the partial second is not lost.
            if (!stop && start) r_state <= RUN;
          end
          EXPIRED: begin
`ifdef COUNTDOWN_FLASH_EN
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
`else
            r_cnt <= '0;
`endif
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

`ifdef COUNTDOWN_FLASH_EN
  assign w_blank = (r_state == EXPIRED) && (r_cnt >= HALF);
`else
  assign w_blank = 1'b0;
`endif

  assign w_colon_n = !(((r_state == RUN) && (r_cnt < HALF)) || (r_state == PAUSE));

  assign m1      = w_blank ? 7'b1111111 : seg7({1'b0, r_m1});
  assign m0      = w_blank ? 7'b1111111 : seg7(r_m0);
  assign s1      = w_blank ? 7'b1111111 : seg7({1'b0, r_s1});
  assign s0      = w_blank ? 7'b1111111 : seg7(r_s0);
  assign dots    = {1'b1, w_colon_n, 2'b11};
  assign running = (r_state == RUN);
  assign expired = (r_state == EXPIRED);
  assign done    = r_done;
endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Bench for countdown_timer_mmss at TICKS_PER_SEC=4: vector table plus expiry/flash sequence.
module tb_countdown_timer_mmss;
  logic       clk = 1'b0;
  logic       rst = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [2:0] ld_m1 = 3'd0, ld_s1 = 3'd0;
  logic [3:0] ld_m0 = 4'd0, ld_s0 = 4'd0;
  logic [6:0] m1, m0, s1, s0;
  logic [3:0] dots;
  logic       running, expired, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  countdown_timer_mmss #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .load(load),
    .ld_m1(ld_m1), .ld_m0(ld_m0), .ld_s1(ld_s1), .ld_s0(ld_s0),
    .start(start), .stop(stop),
    .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .dots(dots), .running(running), .expired(expired), .done(done)
  );

`ifdef COUNTDOWN_FLASH_EN
  localparam logic [3:0] XB = 4'hF;
  localparam bit FLASH = 1'b1;
`else
  localparam logic [3:0] XB = 4'h0;
  localparam bit FLASH = 1'b0;
`endif
  localparam logic [15:0] XB4 = {XB, XB, XB, XB};

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;  4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;  4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;  4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;  4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;  4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  typedef struct {
    string       nm;
    logic        r, ld, go, hold;
    logic [2:0]  a, c;
    logic [3:0]  b, d;
    int          reps;
    logic [15:0] ev;
    logic        erun, eexp, edone;
    logic [3:0]  edots;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string nm, input int r, input int ld,
                              input int a, input int b, input int c, input int d,
                              input int go, input int hold, input int reps,
                              input logic [15:0] ev, input int erun, input int eexp,
                              input int edone, input logic [3:0] edots);
    vec_t v;
    v.nm = nm; v.r = 1'(r); v.ld = 1'(ld);
    v.a = 3'(a); v.b = 4'(b); v.c = 3'(c); v.d = 4'(d);
    v.go = 1'(go); v.hold = 1'(hold); v.reps = reps; v.ev = ev;
    v.erun = 1'(erun); v.eexp = 1'(eexp); v.edone = 1'(edone); v.edots = edots;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic ld, input logic [2:0] a, input logic [3:0] b,
                       input logic [2:0] c, input logic [3:0] d, input logic go, input logic hold);
    rst = r; load = ld; ld_m1 = a; ld_m0 = b; ld_s1 = c; ld_s0 = d; start = go; stop = hold;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [15:0] ev, input logic erun,
                       input logic eexp, input logic edone, input logic [3:0] edots);
    logic [34:0] act, exp;
    act = {m1, m0, s1, s0, dots, running, expired, done};
    exp = {seg(ev[15:12]), seg(ev[11:8]), seg(ev[7:4]), seg(ev[3:0]), edots, erun, eexp, edone};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int done_cnt;
    bit got;
    logic [6:0] exp_seg;

    //   name          rst ld m1 m0 s1 s0 go st reps digits   run exp done dots
    add("reset",        1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 4'hF);
    add("ld0003",       0, 1, 0, 0, 0, 3, 0, 0, 1, 16'h0003, 0, 0, 0, 4'hF);
    add("start",        0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0003, 1, 0, 0, 4'hB);
    add("run_c1",       0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0003, 1, 0, 0, 4'hB);
    add("run_c2",       0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0003, 1, 0, 0, 4'hF);
    add("run_c3",       0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0003, 1, 0, 0, 4'hF);
    add("dec1",         0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 1, 0, 0, 4'hB);
    add("run2_c3",      0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0002, 1, 0, 0, 4'hF);
    add("dec2",         0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 1, 0, 0, 4'hB);
    add("run3_c3",      0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0001, 1, 0, 0, 4'hF);
    add("expire",       0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 1, 4'hF);
    add("done_clear",   0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 0, 4'hF);
    add("exp_c2",       0, 0, 0, 0, 0, 0, 0, 0, 1, XB4,      0, 1, 0, 4'hF);
    add("start_exp",    0, 0, 0, 0, 0, 0, 1, 0, 1, XB4,      0, 1, 0, 4'hF);
    add("stop_exp",     0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 1, 0, 4'hF);
    add("ld0100",       0, 1, 0, 1, 0, 0, 0, 0, 1, 16'h0100, 0, 0, 0, 4'hF);
    add("start0100",    0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0100, 1, 0, 0, 4'hB);
    add("run0100_c3",   0, 0, 0, 0, 0, 0, 0, 0, 3, 16'h0100, 1, 0, 0, 4'hF);
    add("borrow_0059",  0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0059, 1, 0, 0, 4'hB);
    add("ld1000_run",   0, 1, 1, 0, 0, 0, 0, 0, 1, 16'h1000, 0, 0, 0, 4'hF);
    add("start1000",    0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h1000, 1, 0, 0, 4'hB);
    add("borrow_0959",  0, 0, 0, 0, 0, 0, 0, 0, 4, 16'h0959, 1, 0, 0, 4'hB);
    add("ld_saturate",  0, 1, 7, 9, 6,15, 0, 0, 1, 16'h5959, 0, 0, 0, 4'hF);
    add("ld0000",       0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 4'hF);
    add("start_zero",   0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 0, 0, 0, 4'hF);
    add("stop_idle",    0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 0, 0, 0, 4'hF);
    add("ld_and_start", 0, 1, 0, 0, 0, 1, 1, 0, 1, 16'h0001, 0, 0, 0, 4'hF);
    add("start0001",    0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 1, 0, 0, 4'hB);
    add("run0001_c2",   0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0001, 1, 0, 0, 4'hF);
    add("rst_in_run",   1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 4'hF);
    add("after_rst",    0, 0, 0, 0, 0, 0, 0, 0, 6, 16'h0000, 0, 0, 0, 4'hF);
    add("ld0005",       0, 1, 0, 0, 0, 5, 0, 0, 1, 16'h0005, 0, 0, 0, 4'hF);
    add("start0005",    0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0005, 1, 0, 0, 4'hB);
    add("run0005_c2",   0, 0, 0, 0, 0, 0, 0, 0, 2, 16'h0005, 1, 0, 0, 4'hF);
    add("pause",        0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0005, 0, 0, 0, 4'hB);
    add("pause_hold",   0, 0, 0, 0, 0, 0, 0, 0,20, 16'h0005, 0, 0, 0, 4'hB);
    add("pause_stop",   0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0005, 0, 0, 0, 4'hB);
    add("resume",       0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0005, 1, 0, 0, 4'hF);
    add("resume_c3",    0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0005, 1, 0, 0, 4'hF);
    add("dec_resume",   0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0004, 1, 0, 0, 4'hB);
    add("ld_over_stop", 0, 1, 0, 0, 0, 9, 0, 1, 1, 16'h0009, 0, 0, 0, 4'hF);

    @(negedge clk);
    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].reps; k++) begin
        drive(vq[i].r, vq[i].ld, vq[i].a, vq[i].b, vq[i].c, vq[i].d, vq[i].go, vq[i].hold);
        step();
      end
      drive(1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
      check(vq[i].nm, vq[i].ev, vq[i].erun, vq[i].eexp, vq[i].edone, vq[i].edots);
    end

    // Run 00:02 to expiry, count done pulses and follow the expired display.
    drive(1'b0, 1'b1, 3'd0, 4'd0, 3'd0, 4'd2, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    done_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (done) done_cnt++;
      if (expired) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL expire_timeout: expired=%b expected 1 within 20 cycles", expired);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) done_cnt++;
      exp_seg = (FLASH && (((i + 1) % 4) >= 2)) ? 7'b1111111 : 7'b1000000;
      n_tests++;
      if (m1 !== exp_seg || m0 !== exp_seg || s1 !== exp_seg || s0 !== exp_seg || expired !== 1'b1) begin
        n_fail++;
        $display("FAIL exp_display_%0d: got %h %h %h %h exp=%b expected %h x4 exp=1",
                 i, m1, m0, s1, s0, expired, exp_seg);
      end
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_count: got %0d expected 1", done_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
